// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int FETCH_AW    = 32;
  localparam int FETCH_DW    = 32;

  localparam logic [FETCH_AW-1:0] DEFAULT_RESET_PC = '0;

  // Default-width prefetch entry; the top re-declares it at its own widths.
  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: synchronous push/pop, flush, combinational head read.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  entry_t        data_i,
  output entry_t        head_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          pop_eff;

  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  // Popping an empty FIFO is a no-op.
  assign pop_eff = pop_i & valid_o;
  // Head reads as zero while empty so downstream never sees stale entries.
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q + CW'(push_i) - CW'(pop_eff);
  end

  // Pointer/count state; flush wins over any push or pop.
  always_ff @(posedge clk) begin
    if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_eff) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage array; no reset needed since the count gates visibility.
  always_ff @(posedge clk) begin
    if (!flush_i && push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // The issuer's credit check must never let a push land in a full FIFO.
  always_ff @(posedge clk) begin
    if (!flush_i) assert (!(push_i && !pop_eff && count_q == CW'(DEPTH)));
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, credit-based issue to a 1-cycle imem,
// redirect with flush, and a prefetch FIFO toward decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = FETCH_AW,
  parameter int DATA_WIDTH    = FETCH_DW,
  parameter int FIFO_DEPTH    = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     PCsrc,
  input  logic [ADDRESS_WIDTH-1:0] ImmOp,
  input  logic [ADDRESS_WIDTH-1:0] branch_pc,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     instr_valid,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  input  logic                     instr_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic [ADDRESS_WIDTH-1:0] PC_INC    = ADDRESS_WIDTH'(INSTR_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MSK = ~ADDRESS_WIDTH'(INSTR_BYTES - 1);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    instr;
  } entry_t;

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                     inflight_q, inflight_d;
  logic [ADDRESS_WIDTH-1:0] target;
  logic [CW-1:0]            fifo_count;
  logic [OW-1:0]            occ;
  logic                     fifo_valid, pop, push, issue, credit, flush;
  entry_t                   push_ent, head;

  // Redirect target, word-aligned; wraps modulo 2^AW.
  assign target = (branch_pc + ImmOp) & ALIGN_MSK;

  // Pop is ignored on a redirect since the FIFO is being flushed anyway.
  assign pop    = instr_valid & instr_ready & ~PCsrc;
  // Entries held or promised (FIFO + in flight) after this cycle's pop.
  assign occ    = {1'b0, fifo_count} - OW'(pop) + OW'(inflight_q);
  assign credit = occ < OW'(FIFO_DEPTH);
  assign issue  = credit & ~PCsrc & ~rst;

  // A response is dropped if a redirect or reset lands on its arrival cycle.
  assign push   = inflight_q & ~PCsrc & ~rst;
  assign flush  = rst | PCsrc;

  assign push_ent.pc    = inflight_pc_q;
  assign push_ent.instr = imem_rdata;

  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign instr_valid = fifo_valid & ~rst;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  // Next PC and in-flight tracking; redirect outranks sequential issue.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (PCsrc) begin
      pc_d = target;
    end else if (issue) begin
      pc_d          = pc_q + PC_INC;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  // PC/in-flight registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_ent),
    .head_o  (head),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run against a queue-based model of issued-but-not-consumed fetches.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, PCsrc, instr_ready, imem_req, instr_valid;
  logic [31:0] ImmOp, branch_pc, imem_addr, imem_rdata, instr, instr_pc;

  // Second instance to exercise PC wrap from a near-top reset vector.
  logic        rst2, imem_req2, instr_valid2;
  logic [31:0] imem_addr2, imem_rdata2, instr2, instr_pc2;

  int vectors = 0;
  int miscmp  = 0;

  typedef struct { logic [31:0] pc; int t; } ent_t;

  always #5 clk = ~clk;

  // Instruction memory model: word at addr is ~addr, one cycle latency.
  always @(posedge clk) if (imem_req)  imem_rdata  <= ~imem_addr;
  always @(posedge clk) if (imem_req2) imem_rdata2 <= ~imem_addr2;

  fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .PCsrc(PCsrc), .ImmOp(ImmOp), .branch_pc(branch_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready));

  fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst2), .PCsrc(1'b0), .ImmOp(32'h0), .branch_pc(32'h0),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2), .instr_ready(1'b1));

  // Two reset cycles; returns just after the negedge that starts cycle 0.
  task automatic do_reset();
    @(negedge clk); rst = 1'b1; PCsrc = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; PCsrc = 1'b0; instr_ready = 1'b1;
    @(negedge clk); #1;
    vectors++; if (imem_req !== 1'b0) begin miscmp++; $display("FAIL rst_req got=%b want=0", imem_req); end
    vectors++; if (instr_valid !== 1'b0) begin miscmp++; $display("FAIL rst_valid got=%b want=0", instr_valid); end
    @(negedge clk); #1;
    vectors++; if (instr_pc !== 32'h0 || instr !== 32'h0) begin miscmp++; $display("FAIL rst_empty_head pc=%h instr=%h want=0", instr_pc, instr); end
    @(negedge clk); rst = 1'b0; #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscmp++; $display("FAIL rst_first_req req=%b addr=%h want=1/0", imem_req, imem_addr); end
    @(negedge clk); #1;
    vectors++; if (instr_valid !== 1'b0) begin miscmp++; $display("FAIL rst_lat1 valid=%b want=0", instr_valid); end
    @(negedge clk); #1;
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hFFFF_FFFF) begin
      miscmp++; $display("FAIL rst_lat2 valid=%b pc=%h instr=%h want=1/0/ffffffff", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_stream();
    instr_ready = 1'b1; do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c >= 2) begin
        vectors++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (c - 2)) || instr !== ~32'(4 * (c - 2))) begin
          miscmp++; $display("FAIL stream c=%0d valid=%b pc=%h want pc=%h", c, instr_valid, instr_pc, 32'(4 * (c - 2)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b1; do_reset();
    for (int c = 0; c < 13; c++) begin
      if (c > 0) @(negedge clk);
      instr_ready = !(c >= 3 && c < 8);
      #1;
      if (c >= 5 && c < 8) begin
        vectors++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h4) begin
          miscmp++; $display("FAIL bp_hold c=%0d req=%b valid=%b pc=%h want 0/1/4", c, imem_req, instr_valid, instr_pc);
        end
      end
      if (c >= 8) begin
        vectors++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (c - 7))) begin
          miscmp++; $display("FAIL bp_resume c=%0d valid=%b pc=%h want %h", c, instr_valid, instr_pc, 32'(4 * (c - 7)));
        end
      end
    end
  endtask

  // Redirect while streaming (rdy=1) or with FIFO full (rdy=0); checks timing and alignment.
  task automatic test_redirect(input logic rdy, input logic [31:0] bpc, input logic [31:0] imm,
                               input logic [31:0] tgt);
    instr_ready = rdy; do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      PCsrc = (c == 5); branch_pc = bpc; ImmOp = imm;
      #1;
      if (c == 5) begin
        vectors++; if (imem_req !== 1'b0) begin miscmp++; $display("FAIL redir_req c=%0d req=%b want=0", c, imem_req); end
      end
      if (c == 6) begin
        vectors++; if (imem_req !== 1'b1 || imem_addr !== tgt) begin miscmp++; $display("FAIL redir_fetch req=%b addr=%h want 1/%h", imem_req, imem_addr, tgt); end
      end
      if (c == 6 || c == 7) begin
        vectors++; if (instr_valid !== 1'b0) begin miscmp++; $display("FAIL redir_stale c=%0d valid=%b pc=%h want valid 0", c, instr_valid, instr_pc); end
      end
      if (c == 8) begin
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== tgt || instr !== ~tgt) begin
          miscmp++; $display("FAIL redir_target valid=%b pc=%h want 1/%h", instr_valid, instr_pc, tgt); end
      end
    end
    PCsrc = 1'b0;
  endtask

  task automatic test_wrap();
    @(negedge clk); rst2 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c >= 2) begin
        logic [31:0] want;
        want = 32'hFFFF_FFF8 + 32'(4 * (c - 2));
        vectors++;
        if (instr_valid2 !== 1'b1 || instr_pc2 !== want || instr2 !== ~want) begin
          miscmp++; $display("FAIL wrap c=%0d valid=%b pc=%h want %h", c, instr_valid2, instr_pc2, want);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    instr_ready = 1'b1; do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      rst = (c == 5);
      #1;
      if (c == 5) begin
        vectors++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin miscmp++; $display("FAIL mid_rst req=%b valid=%b want 0/0", imem_req, instr_valid); end
      end
      if (c == 6) begin
        vectors++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
          miscmp++; $display("FAIL mid_restart valid=%b req=%b addr=%h want 0/1/0", instr_valid, imem_req, imem_addr); end
      end
      if (c == 8) begin
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin miscmp++; $display("FAIL mid_first valid=%b pc=%h want 1/0", instr_valid, instr_pc); end
      end
    end
  endtask

  // Model: every issued fetch joins a queue tagged with its issue cycle; it is
  // visible to decode two cycles later, consumed in order, and a redirect
  // discards the lot. At most DEPTH may be outstanding.
  task automatic test_random();
    ent_t        q[$];
    logic [31:0] nreq, tgt;
    logic        exp_v, exp_req;
    instr_ready = 1'b1; do_reset();
    nreq = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      instr_ready = ($urandom_range(0, 9) < 7);
      PCsrc       = ($urandom_range(0, 15) == 0);
      branch_pc   = $urandom; ImmOp = $urandom;
      #1;
      exp_v = (q.size() > 0) && (c - q[0].t >= 2);
      vectors++; if (instr_valid !== exp_v) begin miscmp++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, instr_valid, exp_v); end
      if (exp_v) begin
        vectors++; if (instr_pc !== q[0].pc || instr !== ~q[0].pc) begin
          miscmp++; $display("FAIL rnd_head c=%0d pc=%h instr=%h want pc=%h", c, instr_pc, instr, q[0].pc); end
      end else begin
        vectors++; if (instr_pc !== 32'h0 || instr !== 32'h0) begin miscmp++; $display("FAIL rnd_empty c=%0d pc=%h instr=%h want 0", c, instr_pc, instr); end
      end
      if (PCsrc) begin
        vectors++; if (imem_req !== 1'b0) begin miscmp++; $display("FAIL rnd_redir_req c=%0d got=%b want=0", c, imem_req); end
        tgt = (branch_pc + ImmOp) & 32'hFFFF_FFFC;
        q.delete(); nreq = tgt;
      end else begin
        if (exp_v && instr_ready) void'(q.pop_front());
        exp_req = (q.size() < DEPTH);
        vectors++; if (imem_req !== exp_req) begin miscmp++; $display("FAIL rnd_req c=%0d got=%b want=%b", c, imem_req, exp_req); end
        if (exp_req) begin
          vectors++; if (imem_addr !== nreq) begin miscmp++; $display("FAIL rnd_addr c=%0d got=%h want=%h", c, imem_addr, nreq); end
          q.push_back('{pc: nreq, t: c});
          nreq = nreq + 32'd4;
        end
      end
    end
    PCsrc = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; PCsrc = 1'b0; instr_ready = 1'b1;
    ImmOp = '0; branch_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect(1'b1, 32'h10, 32'h20, 32'h30);
    test_redirect(1'b0, 32'h101, 32'h2, 32'h100);
    test_redirect(1'b1, 32'hFFFF_FFF0, 32'h18, 32'h8);
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule
